rdma_multi_qp_fsm: RTL and testbench
====================================

Name: rdma_multi_qp_fsm

Overview:
Parametrised RDMA session controller for the ERNIC data path. It runs the per-host CM handshake (reply, RTU, QPn init) for up to NUM_QP data queue pairs and tracks connected/MR-registered state per QP. Once every active QP has a registered MR, it schedules RDMA writes round-robin across QPs, TRACKS_PER_QP tracks each. Bad requests and handshake stalls go to a recoverable ERROR state with an error code.

Parameters:
NUM_QP, 8, number of data QPs tracked (1..14).
QPN_W, 4, QP number width.
FIRST_DATA_QPN, 2, QPN of data QP index 0. QP index = qpn - FIRST_DATA_QPN.
TRACK_W, 4, width of track-per-QP count.
TIMEOUT_W, 24, width of handshake timeout counter.
TIMEOUT_CYCLES, 24'd10_000_000, handshake wait limit in core_clk cycles.

Ports:
core_clk  in  1  clock
core_areset  in  1  asynchronous active-high reset
clear_session  in  1  synchronous session clear, highest priority
qp1_init_done  in  1  level, QP1 ready
cm_req_valid  in  1  CM REQ received (1-cycle pulse)
cm_req_qpn  in  QPN_W  QPN requested by the host
cm_rtu_valid  in  1  CM ReadyToUse received
cm_reply_tx_en  out  1  1-cycle pulse to start CM REP transmit
cm_reply_tx_done  in  1  REP transmit finished
cm_qpn  out  QPN_W  QPN of the current handshake
qpn_init_en  out  1  1-cycle pulse to initialise QP cm_qpn
qpn_init_done  in  1  QPn init finished
rx_mr_valid  in  1  host MR SEND received
rx_mr_qpn  in  QPN_W  QPN carrying the MR
cmac_m_axis_tready / tvalid / tlast  in  1 each  ACK frame egress observation
active_qp_num  in  4  QPs in use (1..NUM_QP). 0 is treated as 1.
tracks_per_qp  in  TRACK_W  tracks per QP before rotating. 0 is treated as 1.
ddr_write_done  in  1  DDR buffer holds data
rdma_track_done  in  1  current track write finished
rdma_write_ready  out  1  level, high in WAIT_DDR
rdma_write_en  out  1  1-cycle pulse per track
rdma_write_qpn  out  QPN_W  target QPN for the write
qp_connected  out  NUM_QP  per-index connected bitmap
qp_mr_valid  out  NUM_QP  per-index MR-registered bitmap
err_flag  out  1  high in ERROR
err_code  out  3  0 none, 1 REQ before QP1 ready, 2 QPN out of range, 3 timeout
fsm_state  out  4  current state encoding (debug)

Behaviour:
- Reset: all outputs 0. State IDLE (encoding 0). Bitmaps, counters, qp_idx and track_cnt all 0.
- State encodings: IDLE=0, CM_REPLY=1, WAIT_REPLY=2, WAIT_RTU=3, QPN_INIT=4, WAIT_QPN_INIT=5, WAIT_ACK=6, WAIT_DDR=7, WRITE=8, WAIT_WRITE=9, ERROR=10.
- clear_session, any state: next state IDLE. Clears both bitmaps, qp_idx, track_cnt, timeout counter and err_code.
- IDLE, priority order:
  - cm_req_valid & !qp1_init_done -> ERROR, code 1.
  - cm_req_valid with cm_req_qpn out of range -> ERROR, code 2.
  - cm_req_valid valid -> CM_REPLY. Latch cm_qpn. Clear qp_connected and qp_mr_valid for that index (re-handshake).
  - qp_mr_valid[active-1:0] all set -> WAIT_DDR.
  - rx_mr_valid -> WAIT_ACK.
- CM_REPLY -> WAIT_REPLY unconditionally. cm_reply_tx_en is high for this one cycle only.
- WAIT_REPLY -> WAIT_RTU on cm_reply_tx_done.
- WAIT_RTU -> QPN_INIT on cm_rtu_valid.
- QPN_INIT -> WAIT_QPN_INIT. qpn_init_en is high for this one cycle only.
- WAIT_QPN_INIT -> IDLE on qpn_init_done. Set qp_connected[cm_qpn-FIRST_DATA_QPN] in the same edge.
- WAIT_ACK -> IDLE on tready & tvalid & tlast in the same cycle.
- Timeout: counter clears on every state change. It increments in WAIT_REPLY, WAIT_RTU, WAIT_QPN_INIT and WAIT_ACK. When it reaches TIMEOUT_CYCLES-1 with no exit event -> ERROR, code 3. If the exit event and the limit fall in the same cycle, the exit event wins.
- MR capture, independent of state: on rx_mr_valid with the QPN in range and that QP connected, set its qp_mr_valid bit one cycle later. Otherwise the MR is ignored. Capture is suppressed in the cycle clear_session is high.
- WAIT_DDR -> WRITE on ddr_write_done. rdma_write_ready equals (state==WAIT_DDR).
- WRITE -> WAIT_WRITE. rdma_write_en is high for 1 cycle. rdma_write_qpn = FIRST_DATA_QPN + qp_idx, held stable until the next WRITE.
- WAIT_WRITE -> WRITE on rdma_track_done.
  - If track_cnt == eff_tracks-1: track_cnt <= 0; qp_idx <= (qp_idx == eff_active-1) ? 0 : qp_idx+1.
  - Otherwise track_cnt <= track_cnt+1.
- The write loop runs until clear_session. CM/MR inputs arriving during WAIT_DDR, WRITE or WAIT_WRITE are not handshaken. MR capture still applies.
- ERROR is sticky. err_flag = 1 and err_code holds. Only clear_session or core_areset exits.
- active_qp_num > NUM_QP saturates to NUM_QP.

Test Plan:
- Handshake QPN 3 (qp1_init_done=1): REQ -> cm_reply_tx_en pulse with cm_qpn=3; then tx_done, RTU -> qpn_init_en pulse; then init_done -> qp_connected=8'h02, state IDLE.
- REQ with qp1_init_done=0 -> ERROR, err_code=1. Then clear_session -> IDLE, err_code=0, bitmaps 0.
- REQ qpn=12 with NUM_QP=8 -> err_code=2. Handshake with rtu never sent, TIMEOUT_CYCLES=100 -> ERROR, code 3, exactly 100 cycles after entering WAIT_RTU.
- active_qp_num=2: connect QPs 2,3 and send MRs, each followed by an ACK frame -> WAIT_DDR, rdma_write_ready=1. Then ddr_write_done -> WRITE.
- tracks_per_qp=3, active=2: 7 track_done events -> rdma_write_qpn sequence 2,2,2,3,3,3,2,2.
- MR on unconnected QP 4 -> qp_mr_valid unchanged. MR coincident with clear_session -> bit not set.

Source files
------------

// File: rtl/rdma_multi_qp_fsm.sv
// rdma_multi_qp_fsm: per-host CM handshake, per-QP MR tracking and round-robin RDMA write scheduler.
module rdma_multi_qp_fsm #(
  parameter int NUM_QP         = 8,
  parameter int QPN_W          = 4,
  parameter int FIRST_DATA_QPN = 2,
  parameter int TRACK_W        = 4,
  parameter int TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic               core_clk,
  input  logic               core_areset,
  input  logic               clear_session,
  input  logic               qp1_init_done,
  input  logic               cm_req_valid,
  input  logic [QPN_W-1:0]   cm_req_qpn,
  input  logic               cm_rtu_valid,
  output logic               cm_reply_tx_en,
  input  logic               cm_reply_tx_done,
  output logic [QPN_W-1:0]   cm_qpn,
  output logic               qpn_init_en,
  input  logic               qpn_init_done,
  input  logic               rx_mr_valid,
  input  logic [QPN_W-1:0]   rx_mr_qpn,
  input  logic               cmac_m_axis_tready,
  input  logic               cmac_m_axis_tvalid,
  input  logic               cmac_m_axis_tlast,
  input  logic [3:0]         active_qp_num,
  input  logic [TRACK_W-1:0] tracks_per_qp,
  input  logic               ddr_write_done,
  input  logic               rdma_track_done,
  output logic               rdma_write_ready,
  output logic               rdma_write_en,
  output logic [QPN_W-1:0]   rdma_write_qpn,
  output logic [NUM_QP-1:0]  qp_connected,
  output logic [NUM_QP-1:0]  qp_mr_valid,
  output logic               err_flag,
  output logic [2:0]         err_code,
  output logic [3:0]         fsm_state
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_CM_REPLY = 4'd1, S_WAIT_REPLY = 4'd2, S_WAIT_RTU = 4'd3,
    S_QPN_INIT = 4'd4, S_WAIT_QPN_INIT = 4'd5, S_WAIT_ACK = 4'd6, S_WAIT_DDR = 4'd7,
    S_WRITE = 4'd8, S_WAIT_WRITE = 4'd9, S_ERROR = 4'd10
  } state_t;
  localparam logic [QPN_W-1:0]  FQ  = QPN_W'(FIRST_DATA_QPN);
  localparam logic [QPN_W:0]    NQ  = (QPN_W+1)'(NUM_QP);
  localparam logic [3:0]        NQ4 = 4'(NUM_QP);
  localparam logic [NUM_QP-1:0] ONE = NUM_QP'(1);
  state_t               r_state, w_next;
  logic [NUM_QP-1:0]    r_conn, r_mr, r_pend_oh;
  logic                 r_pend;
  logic [QPN_W-1:0]     r_cm_qpn, r_wr_qpn;
  logic [3:0]           r_qp_idx, w_idx_nxt, w_eff_act;
  logic [TRACK_W-1:0]   r_trk, w_trk_nxt, w_eff_trk;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [2:0]           r_err, w_code;
  logic [NUM_QP-1:0]    w_req_oh, w_mr_oh, w_cm_oh, w_act_mask;
  logic                 w_all_mr, w_mr_ok, w_req_go, w_adv, w_trk_last, w_hit, w_timed;
  function automatic logic in_rng(input logic [QPN_W-1:0] q);
    return (q >= FQ) && ({1'b0, q - FQ} < NQ);
  endfunction
  assign w_req_oh   = ONE << (cm_req_qpn - FQ);
  assign w_mr_oh    = ONE << (rx_mr_qpn - FQ);
  assign w_cm_oh    = ONE << (r_cm_qpn - FQ);
  assign w_eff_act  = (active_qp_num == 4'd0) ? 4'd1 : (active_qp_num > NQ4 ? NQ4 : active_qp_num);
  assign w_act_mask = (ONE << w_eff_act) - ONE;
  assign w_all_mr   = &(r_mr | ~w_act_mask);
  assign w_eff_trk  = (tracks_per_qp == '0) ? TRACK_W'(1) : tracks_per_qp;
  assign w_mr_ok    = rx_mr_valid & ~clear_session & in_rng(rx_mr_qpn) & |(r_conn & w_mr_oh);
  assign w_req_go   = (r_state == S_IDLE) & cm_req_valid & qp1_init_done & in_rng(cm_req_qpn);
  assign w_adv      = (r_state == S_WAIT_WRITE) & rdma_track_done;
  assign w_trk_last = r_trk == w_eff_trk - TRACK_W'(1);
  assign w_idx_nxt  = (w_adv & w_trk_last) ? ((r_qp_idx == w_eff_act - 4'd1) ? 4'd0 : r_qp_idx + 4'd1) : r_qp_idx;
  assign w_trk_nxt  = w_adv ? (w_trk_last ? '0 : r_trk + TRACK_W'(1)) : r_trk;
  assign w_hit      = r_tmo == TIMEOUT_CYCLES - TIMEOUT_W'(1);
  assign w_timed    = (r_state == S_WAIT_REPLY) | (r_state == S_WAIT_RTU) |
                      (r_state == S_WAIT_QPN_INIT) | (r_state == S_WAIT_ACK);
  always_comb begin
    w_next = r_state;
    w_code = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (cm_req_valid & ~qp1_init_done) begin w_next = S_ERROR; w_code = 3'd1; end
        else if (cm_req_valid & ~in_rng(cm_req_qpn)) begin w_next = S_ERROR; w_code = 3'd2; end
        else if (cm_req_valid) w_next = S_CM_REPLY;
        else if (w_all_mr) w_next = S_WAIT_DDR;
        else if (rx_mr_valid) w_next = S_WAIT_ACK;
      end
      S_CM_REPLY:      w_next = S_WAIT_REPLY;
      S_WAIT_REPLY:    w_next = cm_reply_tx_done ? S_WAIT_RTU : (w_hit ? S_ERROR : r_state);
      S_WAIT_RTU:      w_next = cm_rtu_valid ? S_QPN_INIT : (w_hit ? S_ERROR : r_state);
      S_QPN_INIT:      w_next = S_WAIT_QPN_INIT;
      S_WAIT_QPN_INIT: w_next = qpn_init_done ? S_IDLE : (w_hit ? S_ERROR : r_state);
      S_WAIT_ACK:      w_next = (cmac_m_axis_tready & cmac_m_axis_tvalid & cmac_m_axis_tlast) ? S_IDLE :
                                (w_hit ? S_ERROR : r_state);
      S_WAIT_DDR:      w_next = ddr_write_done ? S_WRITE : r_state;
      S_WRITE:         w_next = S_WAIT_WRITE;
      S_WAIT_WRITE:    w_next = rdma_track_done ? S_WRITE : r_state;
      default:         w_next = r_state;
    endcase
    if (w_timed && w_next == S_ERROR) w_code = 3'd3;
    if (clear_session) w_next = S_IDLE;
  end
  always_ff @(posedge core_clk or posedge core_areset) begin
    if (core_areset) begin
      r_state   <= S_IDLE;
      r_conn    <= '0;
      r_mr      <= '0;
      r_pend    <= 1'b0;
      r_pend_oh <= '0;
      r_cm_qpn  <= '0;
      r_wr_qpn  <= '0;
      r_qp_idx  <= '0;
      r_trk     <= '0;
      r_tmo     <= '0;
      r_err     <= '0;
    end else if (clear_session) begin
      r_state  <= S_IDLE;
      r_conn   <= '0;
      r_mr     <= '0;
      r_pend   <= 1'b0;
      r_qp_idx <= '0;
      r_trk    <= '0;
      r_tmo    <= '0;
      r_err    <= '0;
    end else begin
      r_state   <= w_next;
      r_tmo     <= (w_next != r_state || !w_timed) ? '0 : r_tmo + TIMEOUT_W'(1);
      r_err     <= (w_next == S_ERROR && r_state != S_ERROR) ? w_code : r_err;
      r_cm_qpn  <= w_req_go ? cm_req_qpn : r_cm_qpn;
      // A fresh REQ for a QP drops its old connection and MR so it re-handshakes cleanly
      r_conn    <= (r_conn & ~(w_req_go ? w_req_oh : '0)) |
                   ((r_state == S_WAIT_QPN_INIT && qpn_init_done) ? w_cm_oh : '0);
      r_mr      <= (r_mr | (r_pend ? r_pend_oh : '0)) & ~(w_req_go ? w_req_oh : '0);
      r_pend    <= w_mr_ok;
      r_pend_oh <= w_mr_oh;
      r_qp_idx  <= w_idx_nxt;
      r_trk     <= w_trk_nxt;
      r_wr_qpn  <= (w_next == S_WRITE) ? FQ + QPN_W'(w_idx_nxt) : r_wr_qpn;
    end
  end
  assign cm_reply_tx_en   = r_state == S_CM_REPLY;
  assign qpn_init_en      = r_state == S_QPN_INIT;
  assign rdma_write_ready = r_state == S_WAIT_DDR;
  assign rdma_write_en    = r_state == S_WRITE;
  assign err_flag         = r_state == S_ERROR;
  assign err_code         = r_err;
  assign cm_qpn           = r_cm_qpn;
  assign rdma_write_qpn   = r_wr_qpn;
  assign qp_connected     = r_conn;
  assign qp_mr_valid      = r_mr;
  assign fsm_state        = r_state;
endmodule

// File: tb/tb_rdma_multi_qp_fsm.sv
// tb_rdma_multi_qp_fsm: table-driven REQ decode checks, handshake/timeout/MR sequences and a write-order scoreboard.
module tb_rdma_multi_qp_fsm;
  logic clk = 0, rst = 1, clear_session = 0, qp1_init_done = 1, cm_req_valid = 0, cm_rtu_valid = 0;
  logic cm_reply_tx_done = 0, qpn_init_done = 0, rx_mr_valid = 0, tready = 0, tvalid = 0, tlast = 0;
  logic ddr_write_done = 0, rdma_track_done = 0;
  logic [3:0] cm_req_qpn = 0, rx_mr_qpn = 0, active_qp_num = 4'd2, tracks_per_qp = 4'd3;
  logic cm_reply_tx_en, qpn_init_en, rdma_write_ready, rdma_write_en, err_flag;
  logic [3:0] cm_qpn, rdma_write_qpn, fsm_state;
  logic [7:0] qp_connected, qp_mr_valid;
  logic [2:0] err_code;
  int n_cmp = 0, n_err = 0;
  int exp_q[$];
  typedef struct { logic qp1; logic [3:0] qpn; logic [3:0] st; logic [2:0] code; } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  rdma_multi_qp_fsm #(.NUM_QP(8), .TIMEOUT_CYCLES(24'd100)) dut (
    .core_clk(clk), .core_areset(rst), .clear_session(clear_session), .qp1_init_done(qp1_init_done),
    .cm_req_valid(cm_req_valid), .cm_req_qpn(cm_req_qpn), .cm_rtu_valid(cm_rtu_valid),
    .cm_reply_tx_en(cm_reply_tx_en), .cm_reply_tx_done(cm_reply_tx_done), .cm_qpn(cm_qpn),
    .qpn_init_en(qpn_init_en), .qpn_init_done(qpn_init_done), .rx_mr_valid(rx_mr_valid),
    .rx_mr_qpn(rx_mr_qpn), .cmac_m_axis_tready(tready), .cmac_m_axis_tvalid(tvalid),
    .cmac_m_axis_tlast(tlast), .active_qp_num(active_qp_num), .tracks_per_qp(tracks_per_qp),
    .ddr_write_done(ddr_write_done), .rdma_track_done(rdma_track_done),
    .rdma_write_ready(rdma_write_ready), .rdma_write_en(rdma_write_en), .rdma_write_qpn(rdma_write_qpn),
    .qp_connected(qp_connected), .qp_mr_valid(qp_mr_valid), .err_flag(err_flag), .err_code(err_code),
    .fsm_state(fsm_state));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step; @(posedge clk); #1; endtask
  task automatic clr; clear_session = 1; step; clear_session = 0; endtask
  task automatic ack; tready = 1; tvalid = 1; tlast = 1; step; tready = 0; tvalid = 0; tlast = 0; endtask
  task automatic mr(input logic [3:0] q); rx_mr_qpn = q; rx_mr_valid = 1; step; rx_mr_valid = 0; endtask
  task automatic to_rtu(input logic [3:0] q);
    cm_req_qpn = q; cm_req_valid = 1; step; cm_req_valid = 0;
    step;
    cm_reply_tx_done = 1; step; cm_reply_tx_done = 0;
    chk("to_rtu_state", fsm_state, 3);
  endtask
  task automatic hs(input logic [3:0] q);
    cm_req_qpn = q; cm_req_valid = 1; step; cm_req_valid = 0;
    chk("hs_rep_en", cm_reply_tx_en, 1);
    chk("hs_cm_qpn", cm_qpn, q);
    step;
    chk("hs_rep_pulse", cm_reply_tx_en, 0);
    chk("hs_wait_reply", fsm_state, 2);
    cm_reply_tx_done = 1; step; cm_reply_tx_done = 0;
    chk("hs_wait_rtu", fsm_state, 3);
    cm_rtu_valid = 1; step; cm_rtu_valid = 0;
    chk("hs_init_en", qpn_init_en, 1);
    step;
    chk("hs_init_pulse", qpn_init_en, 0);
    qpn_init_done = 1; step; qpn_init_done = 0;
    chk("hs_idle", fsm_state, 0);
  endtask
  // Write scoreboard: each observed rdma_write_en pops the next expected QPN
  always @(negedge clk) begin
    if (!rst && rdma_write_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected: got write to %0d expected none", rdma_write_qpn);
      end else chk("wr_qpn", rdma_write_qpn, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int k;
    tbl[0] = '{1'b1, 4'd3,  4'd1,  3'd0};
    tbl[1] = '{1'b0, 4'd3,  4'd10, 3'd1};
    tbl[2] = '{1'b1, 4'd12, 4'd10, 3'd2};
    tbl[3] = '{1'b1, 4'd1,  4'd10, 3'd2};
    tbl[4] = '{1'b1, 4'd9,  4'd1,  3'd0};
    tbl[5] = '{1'b1, 4'd10, 4'd10, 3'd2};
    tbl[6] = '{1'b0, 4'd12, 4'd10, 3'd1};
    tbl[7] = '{1'b1, 4'd2,  4'd1,  3'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", fsm_state, 0);
    chk("rst_conn", qp_connected, 0);
    chk("rst_mr", qp_mr_valid, 0);
    chk("rst_err", {err_flag, err_code}, 0);
    chk("rst_outs", {cm_reply_tx_en, qpn_init_en, rdma_write_ready, rdma_write_en}, 0);
    chk("rst_qpns", {cm_qpn, rdma_write_qpn}, 0);
    rst = 0;
    step;
    hs(3);
    chk("hs3_conn", qp_connected, 8'h02);
    qp1_init_done = 0; cm_req_qpn = 4; cm_req_valid = 1; step; cm_req_valid = 0; qp1_init_done = 1;
    chk("noqp1_err", {err_flag, err_code}, {1'b1, 3'd1});
    step;
    chk("err_sticky", fsm_state, 10);
    clr;
    chk("clr_state", fsm_state, 0);
    chk("clr_code", err_code, 0);
    chk("clr_bitmaps", {qp_connected, qp_mr_valid}, 0);
    for (int i = 0; i < 8; i++) begin
      clr;
      qp1_init_done = tbl[i].qp1; cm_req_qpn = tbl[i].qpn; cm_req_valid = 1;
      step;
      cm_req_valid = 0; qp1_init_done = 1;
      chk($sformatf("tbl%0d_state", i), fsm_state, tbl[i].st);
      chk($sformatf("tbl%0d_code", i), err_code, tbl[i].code);
      chk($sformatf("tbl%0d_flag", i), err_flag, tbl[i].st == 4'd10);
      if (tbl[i].st == 4'd1) chk($sformatf("tbl%0d_cmqpn", i), cm_qpn, tbl[i].qpn);
    end
    clr;
    to_rtu(3);
    k = 0;
    while (fsm_state != 4'd10 && k < 200) begin step; k++; end
    chk("tmo_cycles", k, 100);
    chk("tmo_code", {err_flag, err_code}, {1'b1, 3'd3});
    clr;
    to_rtu(3);
    repeat (99) step;
    chk("tmo_edge_wait", fsm_state, 3);
    cm_rtu_valid = 1; step; cm_rtu_valid = 0;
    chk("tmo_exit_wins", fsm_state, 4);
    clr;
    hs(2);
    hs(3);
    chk("conn_23", qp_connected, 8'h03);
    mr(4);
    chk("mr4_wait_ack", fsm_state, 6);
    step;
    tready = 1; tvalid = 1; tlast = 0; step; tready = 0; tvalid = 0;
    chk("ack_no_tlast", fsm_state, 6);
    ack;
    chk("ack_idle", fsm_state, 0);
    chk("mr_unconnected", qp_mr_valid, 0);
    mr(2);
    step;
    chk("mr2_set", qp_mr_valid, 8'h01);
    ack;
    mr(3);
    step;
    chk("mr3_set", qp_mr_valid, 8'h03);
    ack;
    chk("after_ack_idle", fsm_state, 0);
    step;
    chk("wait_ddr", fsm_state, 7);
    chk("write_ready", rdma_write_ready, 1);
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(2 + (j / 3) % 2);
      if (j == 0) ddr_write_done = 1; else rdma_track_done = 1;
      step;
      ddr_write_done = 0; rdma_track_done = 0;
      chk("wr_state", fsm_state, 8);
      step;
      chk("wr_wait_state", fsm_state, 9);
    end
    step;
    chk("wr_all_seen", exp_q.size(), 0);
    chk("wr_qpn_held", rdma_write_qpn, 2);
    rx_mr_qpn = 2; rx_mr_valid = 1; clear_session = 1; step; rx_mr_valid = 0; clear_session = 0;
    step;
    step;
    chk("mr_clear_supp", qp_mr_valid, 0);
    chk("mr_clear_state", fsm_state, 0);
    active_qp_num = 0;
    hs(2);
    mr(2);
    step;
    ack;
    step;
    chk("active0_ddr", fsm_state, 7);
    clr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
